regfile_mp: RTL and testbench

//   Parametrised register file: 2 async read ports, 1 write port, optional hardwired

---
 rtl/regfile_mp.sv | 123 ++++++++++++
 tb/tb_regfile_mp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// 2R/1W register file with optional zero register, write bypass and a sequential clear engine.
// Reads are combinational, writes land in 1 edge; writes are refused while the clear runs (wr_drop).
module regfile_mp #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 5,
    parameter int                NUM_REGS  = 32,
    parameter bit                ZERO_REG  = 1'b1,
    parameter bit                BYPASS    = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra0,
    output logic [DATA_W-1:0] rd0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int                PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);
    localparam logic [PTR_W-1:0]  LAST_PTR   = PTR_W'(NUM_REGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic              busy_q;
    logic              clr_done_q;
    logic              wr_drop_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic wr_acc;
    logic ra0_ok;
    logic ra1_ok;

    assign wr_acc = we && !busy_q && ({1'b0, wa} < NUM_REGS_L) && !(ZERO_REG && (wa == '0));
    assign ra0_ok = ({1'b0, ra0} < NUM_REGS_L) && !(ZERO_REG && (ra0 == '0));
    assign ra1_ok = ({1'b0, ra1} < NUM_REGS_L) && !(ZERO_REG && (ra1 == '0));

    assign busy     = busy_q;
    assign clr_done = clr_done_q;
    assign wr_drop  = wr_drop_q;

    // Writes and the clear pointer never collide: no write is accepted while busy.
    always_comb begin
        regs_d = regs_q;
        if (wr_acc) begin
            regs_d[wa[PTR_W-1:0]] = wd;
        end
        if (busy_q) begin
            regs_d[ptr_q] = '0;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd0 = '0;
        if (ra0_ok) begin
            rd0 = (BYPASS && wr_acc && (wa == ra0)) ? wd : regs_q[ra0[PTR_W-1:0]];
        end
    end

    always_comb begin
        rd1 = '0;
        if (ra1_ok) begin
            rd1 = (BYPASS && wr_acc && (wa == ra1)) ? wd : regs_q[ra1[PTR_W-1:0]];
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            wr_drop_q  <= we && busy_q;
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr_q == LAST_PTR) begin
                        state_q    <= IDLE;
                        ptr_q      <= '0;
                        busy_q     <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + PTR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a per-cycle reference model of the register file.
module tb_regfile_mp;

    localparam int          NREGS = 32;
    localparam logic [31:0] RV    = 32'd4;

    logic        CLK;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [31:0] rd0;
    logic [4:0]  ra1;
    logic [31:0] rd1;
    logic        clr_req;
    logic        busy;
    logic        clr_done;
    logic        wr_drop;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_REGS(NREGS),
        .ZERO_REG(1'b1), .BYPASS(1'b1), .RESET_VAL(RV)
    ) dut (
        .CLK(CLK), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra0(ra0), .rd0(rd0), .ra1(ra1), .rd1(rd1),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    // Reference model: the array contents, plus how many registers a running clear has wiped.
    logic [31:0] m_regs [NREGS];
    bit          m_busy;
    int          m_cleared;
    bit          m_done;
    bit          m_drop;

    function automatic bit m_accept();
        return we && !m_busy && (int'(wa) < NREGS) && (wa != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (int'(ra) >= NREGS || ra == 5'd0) return 32'd0;
        if (m_accept() && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    always @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) m_regs[i] <= RV;
            m_busy    <= 1'b0;
            m_cleared <= 0;
            m_done    <= 1'b0;
            m_drop    <= 1'b0;
        end else begin
            m_drop <= we && m_busy;
            m_done <= 1'b0;
            if (m_accept()) m_regs[wa] <= wd;
            if (m_busy) begin
                m_regs[m_cleared] <= 32'd0;
                m_cleared         <= m_cleared + 1;
                if (m_cleared == NREGS - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (clr_req) begin
                m_busy    <= 1'b1;
                m_cleared <= 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cmp_rd0", rd0, exp_rd(ra0));
            chk("cmp_rd1", rd1, exp_rd(ra1));
            chk("cmp_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("cmp_clr_done", {31'd0, clr_done}, {31'd0, m_done});
            chk("cmp_wr_drop", {31'd0, wr_drop}, {31'd0, m_drop});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic fill_regs();
        for (int i = 1; i < NREGS; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i);
            tick();
        end
        we = 1'b0;
    endtask

    task automatic check_all(input string nm, input logic [31:0] val);
        for (int a = 0; a < NREGS; a++) begin
            ra0 = 5'(a);
            #1;
            chk(nm, rd0, (a == 0) ? 32'd0 : val);
            tick();
        end
    endtask

    // mode 0 plain, 1 mid-clear reads, 2 refused write + repeated clr_req, 3 reset abort
    task automatic run_clear(input int mode, output int bc, output int dn);
        bit aborted;
        aborted = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        bc = 0;
        dn = 0;
        for (int i = 0; i < 40 && !aborted; i++) begin
            if (busy) bc++;
            if (clr_done) dn++;
            if (mode == 1 && i == 5) begin
                ra0 = 5'd1; ra1 = 5'd31;
                #1;
                chk("t4_mid_rd0_reg1", rd0, 32'd0);
                chk("t4_mid_rd1_reg31", rd1, 32'd31);
            end
            if (mode == 2 && i == 3) begin
                we = 1'b1; wa = 5'd7; wd = 32'd9;
            end
            if (mode == 2 && i == 4) begin
                we = 1'b0;
                chk("t5_wr_drop", {31'd0, wr_drop}, 32'd1);
            end
            if (mode == 2 && i == 10) clr_req = 1'b1;
            if (mode == 2 && i == 11) clr_req = 1'b0;
            if (mode == 3 && i == 10) begin
                rst = 1'b0;
                #1;
                chk("t6_abort_busy", {31'd0, busy}, 32'd0);
                chk("t6_abort_done", {31'd0, clr_done}, 32'd0);
                check_all("t6_reset_val", RV);
                rst = 1'b1;
                aborted = 1'b1;
            end
            if (!aborted) tick();
        end
    endtask

    initial begin
        int bc;
        int dn;
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0;
        ra0 = '0; ra1 = '0; clr_req = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b1;

        ra0 = 5'd5; ra1 = 5'd0;
        #1;
        chk("t1_rd0_reset_val", rd0, 32'd4);
        chk("t1_rd1_zero_reg", rd1, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_wr_drop", {31'd0, wr_drop}, 32'd0);
        tick();

        we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF; ra0 = 5'd3; ra1 = 5'd3;
        #1;
        chk("t2_bypass_rd0", rd0, 32'hDEADBEEF);
        chk("t2_bypass_rd1", rd1, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        #1;
        chk("t2_stored_rd0", rd0, 32'hDEADBEEF);
        tick();

        we = 1'b1; wa = 5'd0; wd = 32'h1234; ra0 = 5'd0;
        #1;
        chk("t3_zero_bypass", rd0, 32'd0);
        tick();
        we = 1'b0;
        #1;
        chk("t3_zero_stored", rd0, 32'd0);
        chk("t3_wr_drop", {31'd0, wr_drop}, 32'd0);
        tick();

        fill_regs();
        ra0 = 5'd17; ra1 = 5'd31;
        #1;
        chk("t4_fill_rd0", rd0, 32'd17);
        chk("t4_fill_rd1", rd1, 32'd31);
        tick();
        run_clear(1, bc, dn);
        chk("t4_busy_cycles", 32'(bc), 32'd32);
        chk("t4_done_pulses", 32'(dn), 32'd1);
        check_all("t4_cleared", 32'd0);

        fill_regs();
        run_clear(2, bc, dn);
        chk("t5_busy_cycles", 32'(bc), 32'd32);
        chk("t5_done_pulses", 32'(dn), 32'd1);
        ra0 = 5'd7;
        #1;
        chk("t5_reg7_refused", rd0, 32'd0);
        tick();

        fill_regs();
        run_clear(3, bc, dn);
        tick();
        run_clear(0, bc, dn);
        chk("t6_busy_cycles", 32'(bc), 32'd32);
        chk("t6_done_pulses", 32'(dn), 32'd1);
        check_all("t6_cleared", 32'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
